// File: rtl/sram1024x8_req_ctrl.sv
// Valid/ready request front end for a 1024x8 bit-masked SRAM macro. It runs a clear
// sweep after reset and on request, and queues read data in a credit-checked response FIFO.
module sram1024x8_req_ctrl #(
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter logic [7:0]  INIT_VALUE    = 8'h00,
  parameter int unsigned RSP_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [9:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [7:0] req_wmask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  input  logic       clr_req,
  output logic       busy,
  output logic       CEN,
  output logic       GWEN,
  output logic [7:0] WEN,
  output logic [9:0] A,
  output logic [7:0] D,
  input  logic [7:0] Q
);
  localparam int unsigned   PW       = $clog2(RSP_DEPTH);
  localparam int unsigned   CW       = $clog2(RSP_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(RSP_DEPTH);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;
  localparam state_t RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_t        state_q, state_d;
  logic [9:0]    sweep_cnt_q, sweep_cnt_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic [9:0]    a_q, a_d;
  logic [7:0]    d_q, d_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [RSP_DEPTH];
  logic [CW:0]   credits_used;
  logic          fire, push, pop;
  logic          cen_c, gwen_c;
  logic [7:0]    wen_c;

  // Handshake and FIFO status: req_ready depends only on registered state.
  always_comb begin
    credits_used = {1'b0, count_q} + (CW+1)'(rd_inflight_q);
    req_ready    = RSTN && (state_q == ST_RUN) && (credits_used < DEPTH_C);
    busy         = (state_q != ST_RUN);
    fire         = req_valid && req_ready;
    rsp_valid    = (count_q != '0);
    rsp_rdata    = mem_q[rd_ptr_q];
    push         = rd_inflight_q;
    pop          = rsp_valid && rsp_ready;
  end

  always_comb begin
    cen_c         = 1'b1;
    gwen_c        = 1'b1;
    wen_c         = '1;
    a_d           = a_q;
    d_d           = d_q;
    sweep_cnt_d   = sweep_cnt_q;
    state_d       = state_q;
    rd_inflight_d = fire && !req_we;
    unique case (state_q)
      ST_INIT: begin
        cen_c       = 1'b0;
        gwen_c      = 1'b0;
        wen_c       = '0;
        a_d         = sweep_cnt_q;
        d_d         = INIT_VALUE;
        sweep_cnt_d = sweep_cnt_q + 10'd1;
        if (sweep_cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        cen_c  = !fire;
        gwen_c = !req_we;
        wen_c  = req_we ? ~req_wmask : '1;
        if (fire) begin
          a_d = req_addr;
          d_d = req_wdata;
        end
        if (clr_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rd_inflight_q) begin
          state_d     = ST_INIT;
          sweep_cnt_d = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // a_d/d_d are the driven address/data; registering them keeps A and D quiet while idle.
  always_comb begin
    CEN  = RSTN ? cen_c  : 1'b1;
    GWEN = RSTN ? gwen_c : 1'b1;
    WEN  = RSTN ? wen_c  : '1;
    A    = RSTN ? a_d    : '0;
    D    = RSTN ? d_d    : '0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= RESET_STATE;
      sweep_cnt_q   <= '0;
      rd_inflight_q <= 1'b0;
      a_q           <= '0;
      d_q           <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      sweep_cnt_q   <= sweep_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      a_q           <= a_d;
      d_q           <= d_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Macro Q is valid one edge after the read was accepted.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= Q;
  end

endmodule

// File: tb/tb_sram1024x8_req_ctrl.sv
// Scoreboard bench for sram1024x8_req_ctrl: behavioural SRAM macro, reference memory
// image, expected-response queue and an independent negedge monitor.
module tb_sram1024x8_req_ctrl;
  localparam logic [7:0] INIT_VAL = 8'h00;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       req_valid, req_ready, req_we;
  logic [9:0] req_addr;
  logic [7:0] req_wdata, req_wmask;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       clr_req, busy, CEN, GWEN;
  logic [7:0] WEN, D, Q;
  logic [9:0] A;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned rdy_mode = 1;
  logic        rnd_rdy = 1'b0;

  logic [7:0] macro_mem [1024];
  logic [7:0] ref_mem [1024];
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;
  logic [9:0] last_a = '0;
  logic [7:0] last_d = '0;
  int unsigned last_pop_cyc = 0, run_len = 0, pops = 0;

  sram1024x8_req_ctrl #(.INIT_ON_RESET(1'b1), .INIT_VALUE(INIT_VAL), .RSP_DEPTH(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .clr_req(clr_req), .busy(busy), .CEN(CEN),
    .GWEN(GWEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  assign rsp_ready = (rdy_mode == 2) ? rnd_rdy : (rdy_mode == 1);

  // Behavioural 1024x8 bit-masked macro, starting with garbage contents.
  initial begin
    for (int i = 0; i < 1024; i++) macro_mem[i] = 8'($urandom());
    forever begin
      @(posedge CLK);
      if (!CEN) begin
        if (!GWEN) macro_mem[A] <= (macro_mem[A] & WEN) | (D & ~WEN);
        else       Q <= macro_mem[A];
      end
    end
  end

  initial forever begin
    logic [31:0] r;
    @(posedge CLK);
    cyc++;
    r = $urandom();
    rnd_rdy <= r[0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake and polices idle pins.
  initial forever begin
    @(negedge CLK);
    if (RSTN && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_rdata), 32'hFFFF_FFFF);
      end else begin
        exp_v = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_v));
      end
      run_len = (pops != 0 && last_pop_cyc + 1 == cyc) ? run_len + 1 : 1;
      last_pop_cyc = cyc;
      pops++;
    end
    if (RSTN && !busy && !(req_valid && req_ready))
      chk("idle_pins", 32'({CEN, A, D}), 32'({1'b1, last_a, last_d}));
  end

  task automatic try_issue(input bit we, input logic [9:0] a, input logic [7:0] wd,
                           input logic [7:0] wm, input int unsigned max_wait,
                           output bit ok, output int unsigned waited);
    ok = 1'b0;
    waited = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wmask = wm;
    while (!ok && waited < max_wait) begin
      @(negedge CLK);
      if (req_ready) begin
        ok = 1'b1;
        chk("req_pins", 32'({CEN, GWEN, WEN, A, D}),
            32'({1'b0, ~we, (we ? ~wm : 8'hFF), a, wd}));
        last_a = a;
        last_d = wd;
        if (we) ref_mem[a] = (ref_mem[a] & ~wm) | (wd & wm);
        else    exp_q.push_back(ref_mem[a]);
      end else begin
        waited++;
      end
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic issue(input bit we, input logic [9:0] a, input logic [7:0] wd, input logic [7:0] wm);
    bit ok;
    int unsigned w;
    try_issue(we, a, wd, wm, 300, ok, w);
    chk("req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    int unsigned g = 0;
    while ((exp_q.size() != 0 || rsp_valid) && g < 500) begin
      @(posedge CLK); #1;
      g++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  // Follows a DRAIN (if any) and the INIT sweep; afterwards the whole array is INIT_VAL.
  task automatic check_sweep();
    int unsigned n = 0, drain = 0, bad = 0, guard = 0;
    while (guard < 1200) begin
      @(negedge CLK);
      guard++;
      if (guard == 1) chk("sweep_busy_first", 32'(busy), 32'd1);
      if (!busy) break;
      if (req_ready) bad++;
      if (CEN) begin
        drain++;
      end else begin
        if ({GWEN, WEN, A, D} !== {1'b0, 8'h00, n[9:0], INIT_VAL}) bad++;
        last_a = n[9:0];
        last_d = INIT_VAL;
        n++;
      end
    end
    chk("sweep_cycles", 32'(n), 32'd1024);
    chk("sweep_bad_cycles", 32'(bad), 32'd0);
    chk("drain_cycles_le2", 32'(drain <= 2), 32'd1);
    chk("ready_after_sweep", 32'(req_ready), 32'd1);
    for (int i = 0; i < 1024; i++) ref_mem[i] = INIT_VAL;
    @(posedge CLK); #1;
  endtask

  initial begin
    bit ok;
    int unsigned w, acc, tot, g;
    logic [31:0] r;
    logic [7:0] wm;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    clr_req = 1'b0; RSTN = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_pins", 32'({CEN, GWEN, WEN, A, D, rsp_valid, req_ready}),
        32'({1'b1, 1'b1, 8'hFF, 10'd0, 8'd0, 1'b0, 1'b0}));
    @(posedge CLK); #1 RSTN = 1'b1;
    check_sweep();

    // Top word reads back the sweep value.
    issue(1'b0, 10'h3FF, 8'h5A, 8'h00);
    wait_drain();

    // Full write, partial write, read: latency and merged data.
    issue(1'b1, 10'h155, 8'hA5, 8'hFF);
    issue(1'b1, 10'h155, 8'h0F, 8'h0F);
    issue(1'b0, 10'h155, 8'h00, 8'h00);
    @(negedge CLK);
    chk("read_latency_edge1", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    chk("read_latency_edge2", 32'(rsp_valid), 32'd1);
    chk("rmw_data", 32'(rsp_rdata), 32'h0000_00AF);
    @(posedge CLK); #1;
    wait_drain();

    // Backpressure: only RSP_DEPTH reads accepted while rsp_ready is low.
    for (int i = 0; i < 6; i++) issue(1'b1, 10'(32 + i), 8'(8'h30 + i), 8'hFF);
    rdy_mode = 0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      try_issue(1'b0, 10'(32 + i), 8'h00, 8'h00, 4, ok, w);
      if (ok) acc++;
    end
    chk("accepted_under_backpressure", 32'(acc), 32'd4);
    chk("queued_responses", 32'(exp_q.size()), 32'd4);
    @(negedge CLK);
    chk("ready_low_when_full", 32'(req_ready), 32'd0);
    @(posedge CLK); #1;
    rdy_mode = 1;
    issue(1'b0, 10'd36, 8'h00, 8'h00);
    issue(1'b0, 10'd37, 8'h00, 8'h00);
    wait_drain();

    // Sixteen back-to-back reads: no stalls, responses on consecutive cycles.
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      try_issue(1'b0, r[9:0], r[17:10], 8'h00, 300, ok, w);
      chk("b2b_accepted", 32'(ok), 32'd1);
      tot += w;
    end
    chk("b2b_stalls", 32'(tot), 32'd0);
    wait_drain();
    chk("b2b_run_len", 32'(run_len), 32'd16);

    // Randomised traffic over a small address window with random rsp_ready.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      wm = (r[23:21] == 3'd0) ? 8'h00 : r[20:13];
      issue(r[0], {6'd0, r[4:1]}, r[12:5], wm);
      if (r[25:24] == 2'd0) begin
        @(posedge CLK); #1;
      end
    end
    rdy_mode = 1;
    wait_drain();

    // Clear with three reads queued; clr_req coincides with the third read.
    for (int i = 0; i < 3; i++) issue(1'b1, 10'(64 + i), 8'(8'hC1 + i), 8'hFF);
    rdy_mode = 0;
    issue(1'b0, 10'd64, 8'h00, 8'h00);
    issue(1'b0, 10'd65, 8'h00, 8'h00);
    clr_req = 1'b1;
    issue(1'b0, 10'd66, 8'h00, 8'h00);
    clr_req = 1'b0;
    check_sweep();
    chk("queued_survive_clear", 32'(exp_q.size()), 32'd3);
    chk("rsp_valid_after_clear", 32'(rsp_valid), 32'd1);
    rdy_mode = 1;
    wait_drain();
    for (int i = 0; i < 1024; i++) begin
      r = $urandom();
      issue(1'b0, 10'(i), r[7:0], r[15:8]);
    end
    wait_drain();

    // Reset in the middle of a sweep.
    clr_req = 1'b1;
    @(posedge CLK); #1 clr_req = 1'b0;
    g = 0;
    do begin
      @(negedge CLK);
      g++;
    end while (!(busy && !CEN && A == 10'd500) && g < 1500);
    chk("sweep_reached_500", 32'(A), 32'd500);
    #1 RSTN = 1'b0;
    #1;
    chk("reset_mid_sweep_pins", 32'({CEN, rsp_valid, A}), 32'({1'b1, 1'b0, 10'd0}));
    exp_q.delete();
    last_a = '0; last_d = '0;
    @(posedge CLK); @(posedge CLK); #1 RSTN = 1'b1;
    check_sweep();

    // Reset with one response queued and one read in flight.
    rdy_mode = 0;
    issue(1'b0, 10'd5, 8'h00, 8'h00);
    issue(1'b0, 10'd7, 8'h00, 8'h00);
    RSTN = 1'b0;
    #1;
    chk("reset_inflight_pins", 32'({CEN, rsp_valid}), 32'({1'b1, 1'b0}));
    exp_q.delete();
    last_a = '0; last_d = '0;
    @(posedge CLK); @(posedge CLK); #1 RSTN = 1'b1;
    check_sweep();
    @(negedge CLK);
    chk("fifo_discarded_by_reset", 32'(rsp_valid), 32'd0);
    @(posedge CLK); #1;
    rdy_mode = 1;
    issue(1'b0, 10'd7, 8'h00, 8'h00);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "time limit");
  end

endmodule
